alu_result_stage: RTL

Registered output stage directly downstream of the 32-bit ALU comparator and the other ALU datapaths. It captures each ALU/comparator result with its destination tag, forces comparator results to the canonical form (upper 31 bits zero, bit 0 = signed A>B), and derives zero/negative flags. A 2-entry skid buffer with valid/ready handshakes on both sides decouples the combinational ALU from writeback. It also keeps a sticky copy of the last comparator outcome for branch logic.

---
 rtl/alu_result_stage.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/alu_result_stage.sv
// rtl/alu_result_stage.sv - registered ALU result stage with 2-entry skid buffer and sticky compare flag
module alu_result_stage #(
   parameter int WIDTH = 32,
   parameter int TAG_W = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_result,
   input  logic [TAG_W-1:0] in_tag,
   input  logic             in_is_cmp,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_result,
   output logic [TAG_W-1:0] out_tag,
   output logic             out_zero,
   output logic             out_neg,
   output logic             cmp_flag,
   output logic [1:0]       occupancy
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   head_result_q, head_result_d;
   logic [TAG_W-1:0]   head_tag_q, head_tag_d;
   logic               head_zero_q, head_zero_d;
   logic               head_neg_q, head_neg_d;
   logic [WIDTH-1:0]   skid_result_q, skid_result_d;
   logic [TAG_W-1:0]   skid_tag_q, skid_tag_d;
   logic               skid_zero_q, skid_zero_d;
   logic               skid_neg_q, skid_neg_d;
   logic               cmp_flag_q, cmp_flag_d;

   logic               accept;
   logic               pop;
   logic [WIDTH-1:0]   masked;
   logic               masked_zero;
   logic               masked_neg;

   // Canonicalise comparator results and precompute flags before storage
   always_comb begin
      masked = in_result;
      if (in_is_cmp) begin
         masked = {{(WIDTH-1){1'b0}}, in_result[0]};
      end
      masked_zero = (masked == '0);
      masked_neg  = masked[WIDTH-1];
   end

   // Handshake and output decode, all from registered state
   always_comb begin
      in_ready   = (state_q != TWO);
      out_valid  = (state_q != EMPTY);
      accept     = in_valid & in_ready;
      pop        = out_valid & out_ready;
      out_result = head_result_q;
      out_tag    = head_tag_q;
      out_zero   = head_zero_q;
      out_neg    = head_neg_q;
      cmp_flag   = cmp_flag_q;
      occupancy  = state_q;
   end

   // Next-state and entry movement; flush overrides the state but not cmp_flag
   always_comb begin
      state_d       = state_q;
      head_result_d = head_result_q;
      head_tag_d    = head_tag_q;
      head_zero_d   = head_zero_q;
      head_neg_d    = head_neg_q;
      skid_result_d = skid_result_q;
      skid_tag_d    = skid_tag_q;
      skid_zero_d   = skid_zero_q;
      skid_neg_d    = skid_neg_q;
      cmp_flag_d    = cmp_flag_q;

      if (accept && in_is_cmp) begin
         cmp_flag_d = in_result[0];
      end

      case (state_q)
         EMPTY: begin
            if (accept) begin
               state_d       = ONE;
               head_result_d = masked;
               head_tag_d    = in_tag;
               head_zero_d   = masked_zero;
               head_neg_d    = masked_neg;
            end
         end
         ONE: begin
            if (accept && pop) begin
               head_result_d = masked;
               head_tag_d    = in_tag;
               head_zero_d   = masked_zero;
               head_neg_d    = masked_neg;
            end else if (accept) begin
               state_d       = TWO;
               skid_result_d = masked;
               skid_tag_d    = in_tag;
               skid_zero_d   = masked_zero;
               skid_neg_d    = masked_neg;
            end else if (pop) begin
               state_d = EMPTY;
            end
         end
         TWO: begin
            if (pop) begin
               state_d       = ONE;
               head_result_d = skid_result_q;
               head_tag_d    = skid_tag_q;
               head_zero_d   = skid_zero_q;
               head_neg_d    = skid_neg_q;
            end
         end
         default: state_d = EMPTY;
      endcase

      if (flush) begin
         state_d = EMPTY;
      end
   end

   // State, entry and sticky-flag registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= EMPTY;
         head_result_q <= '0;
         head_tag_q    <= '0;
         head_zero_q   <= 1'b0;
         head_neg_q    <= 1'b0;
         skid_result_q <= '0;
         skid_tag_q    <= '0;
         skid_zero_q   <= 1'b0;
         skid_neg_q    <= 1'b0;
         cmp_flag_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         head_result_q <= head_result_d;
         head_tag_q    <= head_tag_d;
         head_zero_q   <= head_zero_d;
         head_neg_q    <= head_neg_d;
         skid_result_q <= skid_result_d;
         skid_tag_q    <= skid_tag_d;
         skid_zero_q   <= skid_zero_d;
         skid_neg_q    <= skid_neg_d;
         cmp_flag_q    <= cmp_flag_d;
      end
   end

endmodule
